// File: rtl/compare_seq.sv
// compare_seq: multi-cycle magnitude/equality comparator.
//
// Compares two WIDTH-bit operands CHUNK bits per cycle, starting from the
// most significant chunk. The compare is signed only when both operands
// are flagged signed; any other mix is compared unsigned. Every transaction
// produces the full relation vector and the result of the selected op.
//
// Parameters:
//   WIDTH      operand width in bits; must be a multiple of CHUNK
//   CHUNK      bits compared per cycle
//   EARLY_EXIT 1: finish at the first differing chunk; 0: always WIDTH/CHUNK steps
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand transaction valid
//   in_ready   block can accept a transaction (IDLE and not in reset)
//   a, b       operands
//   a_signed   operand A is signed
//   b_signed   operand B is signed
//   op         0=LT 1=LE 2=GT 3=GE 4=EQ 5=NE; 6 and 7 are illegal
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     outcome of the selected op for A op B
//   res_vec    {lt,le,gt,ge,eq,ne} for A vs B, independent of op
//   op_err     captured op was 6 or 7
module compare_seq #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned CHUNK      = 16,
    parameter int unsigned EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic [5:0]       res_vec,
    output logic             op_err
);

    localparam int unsigned NSTEP  = WIDTH / CHUNK;
    localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_cfg_check
            $error("compare_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [WIDTH-1:0]    a_sh, a_sh_n;
    logic [WIDTH-1:0]    b_sh, b_sh_n;
    logic [2:0]          op_q, op_q_n;
    logic [STEP_W-1:0]   step, step_n;
    logic                decided, decided_n;
    logic                lt_q, lt_n;
    logic                out_valid_n;
    logic                result_n;
    logic [5:0]          res_vec_n;
    logic                op_err_n;

    // Chunk-level compare of the current most significant chunk.
    logic [CHUNK-1:0]    chunk_a, chunk_b;
    logic                dec_now, lt_now, gt_now, eq_now;
    logic [5:0]          vec_now;

    assign in_ready = rst_n & (state == IDLE);

    // Operands are shifted left one chunk per step so the chunk under test is
    // always the top slice; this replaces a variable part-select by step index.
    assign chunk_a = a_sh[WIDTH-1 -: CHUNK];
    assign chunk_b = b_sh[WIDTH-1 -: CHUNK];

    // Only the first differing chunk decides; later chunks leave lt alone.
    assign dec_now = decided | (chunk_a != chunk_b);
    assign lt_now  = decided ? lt_q : (chunk_a < chunk_b);
    assign gt_now  = dec_now & ~lt_now;
    assign eq_now  = ~dec_now;
    assign vec_now = {lt_now, lt_now | eq_now, gt_now, gt_now | eq_now, eq_now, dec_now};

    always_comb begin
        state_n     = state;
        a_sh_n      = a_sh;
        b_sh_n      = b_sh;
        op_q_n      = op_q;
        step_n      = step;
        decided_n   = decided;
        lt_n        = lt_q;
        out_valid_n = out_valid;
        result_n    = result;
        res_vec_n   = res_vec;
        op_err_n    = op_err;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_n    = a;
                    b_sh_n    = b;
                    // Flipping both sign bits maps two's-complement order
                    // onto unsigned order, so RUN only ever compares unsigned.
                    if (a_signed && b_signed) begin
                        a_sh_n[WIDTH-1] = ~a[WIDTH-1];
                        b_sh_n[WIDTH-1] = ~b[WIDTH-1];
                    end
                    op_q_n    = op;
                    step_n    = '0;
                    decided_n = 1'b0;
                    lt_n      = 1'b0;
                    state_n   = RUN;
                end
            end

            RUN: begin
                decided_n = dec_now;
                lt_n      = lt_now;
                if (((EARLY_EXIT != 0) && dec_now) || (step == LAST_STEP)) begin
                    res_vec_n = vec_now;
                    op_err_n  = 1'b0;
                    case (op_q)
                        3'd0:    result_n = vec_now[5];
                        3'd1:    result_n = vec_now[4];
                        3'd2:    result_n = vec_now[3];
                        3'd3:    result_n = vec_now[2];
                        3'd4:    result_n = vec_now[1];
                        3'd5:    result_n = vec_now[0];
                        default: begin
                            result_n = 1'b0;
                            op_err_n = 1'b1;
                        end
                    endcase
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    step_n = step + 1'b1;
                    a_sh_n = a_sh << CHUNK;
                    b_sh_n = b_sh << CHUNK;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= '0;
            step      <= '0;
            decided   <= 1'b0;
            lt_q      <= 1'b0;
            out_valid <= 1'b0;
            result    <= 1'b0;
            res_vec   <= '0;
            op_err    <= 1'b0;
        end else begin
            state     <= state_n;
            a_sh      <= a_sh_n;
            b_sh      <= b_sh_n;
            op_q      <= op_q_n;
            step      <= step_n;
            decided   <= decided_n;
            lt_q      <= lt_n;
            out_valid <= out_valid_n;
            result    <= result_n;
            res_vec   <= res_vec_n;
            op_err    <= op_err_n;
        end
    end

endmodule

// File: tb/tb_compare_seq.sv
// Testbench for compare_seq: two instances (EARLY_EXIT=0 and EARLY_EXIT=1)
// share the input stimulus; each is checked against a behavioural model
// that uses plain signed/unsigned arithmetic on the whole operands.
module tb_compare_seq;

    localparam int NS = 4;
    localparam int C  = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, a_signed, b_signed, out_ready;
    logic [63:0] a, b;
    logic [2:0]  op;

    logic        rdy0, ov0, res0, err0;
    logic [5:0]  vec0;
    logic        rdy1, ov1, res1, err1;
    logic [5:0]  vec1;

    int n_checks = 0;
    int n_fail   = 0;

    compare_seq #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .op(op),
        .out_valid(ov0), .out_ready(out_ready), .result(res0),
        .res_vec(vec0), .op_err(err0)
    );

    compare_seq #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .op(op),
        .out_valid(ov1), .out_ready(out_ready), .result(res1),
        .res_vec(vec1), .op_err(err1)
    );

    // Packed observation/expectation: {result, res_vec[5:0], op_err, latency[7:0]}
    function automatic logic [15:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mas, input logic mbs,
                                          input logic [2:0] mop, input bit ee);
        logic       lt, eq, gt, r, e;
        logic [5:0] v;
        logic [63:0] sa, sb;
        int         j;
        bit         found;
        eq = (ma == mb);
        if (mas && mbs) lt = ($signed(ma) < $signed(mb));
        else            lt = (ma < mb);
        gt = !lt && !eq;
        v  = {lt, lt | eq, gt, gt | eq, eq, !eq};
        e  = (mop > 3'd5);
        r  = 1'b0;
        case (mop)
            3'd0: r = lt;
            3'd1: r = lt | eq;
            3'd2: r = gt;
            3'd3: r = gt | eq;
            3'd4: r = eq;
            3'd5: r = !eq;
            default: r = 1'b0;
        endcase
        j = NS;
        found = 1'b0;
        if (ee) begin
            for (int i = 0; i < NS; i++) begin
                sa = ma >> (C * (NS - 1 - i));
                sb = mb >> (C * (NS - 1 - i));
                if (!found && (sa[15:0] != sb[15:0])) begin
                    found = 1'b1;
                    j = i + 1;
                end
            end
        end
        return {r, v, e, 8'(j)};
    endfunction

    // Issues one transaction with out_ready held high and captures what each
    // instance presents on the first cycle its out_valid is seen.
    task automatic do_txn(input logic [63:0] ta, input logic [63:0] tb,
                          input logic tas, input logic tbs, input logic [2:0] top,
                          output logic [15:0] o0, output logic [15:0] o1);
        int n;
        bit s0, s1;
        out_ready = 1'b1;
        n = 0;
        while (!(rdy0 && rdy1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL txn_ready_timeout: in_ready=%b/%b required 1/1", rdy0, rdy1);
        end
        a = ta; b = tb; a_signed = tas; b_signed = tbs; op = top;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Inputs must be ignored once the transaction is captured.
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        a_signed = 1'($urandom); b_signed = 1'($urandom); op = 3'($urandom);
        s0 = 1'b0; s1 = 1'b0; o0 = '1; o1 = '1;
        n = 0;
        while (!(s0 && s1) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!s0 && ov0) begin s0 = 1'b1; o0 = {res0, vec0, err0, 8'(n)}; end
            if (!s1 && ov1) begin s1 = 1'b1; o1 = {res1, vec1, err1, 8'(n)}; end
        end
        if (!(s0 && s1)) begin
            n_checks++; n_fail++;
            $display("FAIL txn_valid_timeout: out_valid seen=%b/%b required 1/1", s0, s1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rdy0, ov0, res0, err0, vec0} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state_ee0: got rdy/ov/res/err/vec=%b required all 0", {rdy0, ov0, res0, err0, vec0});
        end
        n_checks++;
        if ({rdy1, ov1, res1, err1, vec1} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state_ee1: got rdy/ov/res/err/vec=%b required all 0", {rdy1, ov1, res1, err1, vec1});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 11", {rdy0, rdy1});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_lt();
        logic [15:0] o0, o1, e0, e1;
        do_txn(64'd5, 64'd7, 1'b0, 1'b0, 3'd0, o0, o1);
        e0 = model(64'd5, 64'd7, 1'b0, 1'b0, 3'd0, 1'b0);
        e1 = model(64'd5, 64'd7, 1'b0, 1'b0, 3'd0, 1'b1);
        n_checks++;
        if (o0 !== e0) begin n_fail++; $display("FAIL unsigned_lt_ee0: got %h required %h", o0, e0); end
        n_checks++;
        if (o1 !== e1) begin n_fail++; $display("FAIL unsigned_lt_ee1: got %h required %h", o1, e1); end
        n_checks++;
        if (o0 !== {1'b1, 6'b110001, 1'b0, 8'd4}) begin
            n_fail++;
            $display("FAIL unsigned_lt_plan: got %h required %h", o0, {1'b1, 6'b110001, 1'b0, 8'd4});
        end
    endtask

    task automatic test_signed_mix();
        logic [15:0] o0, o1, e0;
        do_txn('1, 64'd1, 1'b0, 1'b1, 3'd2, o0, o1);
        e0 = model('1, 64'd1, 1'b0, 1'b1, 3'd2, 1'b0);
        n_checks++;
        if (o0 !== e0 || o0[15] !== 1'b1) begin n_fail++; $display("FAIL signed_mix_unsigned: got %h required %h", o0, e0); end
        n_checks++;
        if (o1 !== model('1, 64'd1, 1'b0, 1'b1, 3'd2, 1'b1)) begin
            n_fail++; $display("FAIL signed_mix_unsigned_ee1: got %h required %h", o1, model('1, 64'd1, 1'b0, 1'b1, 3'd2, 1'b1));
        end
        do_txn('1, 64'd1, 1'b1, 1'b1, 3'd2, o0, o1);
        e0 = model('1, 64'd1, 1'b1, 1'b1, 3'd2, 1'b0);
        n_checks++;
        if (o0 !== e0 || o0[15:9] !== 7'b0110001) begin n_fail++; $display("FAIL signed_both: got %h required %h", o0, e0); end
        n_checks++;
        if (o1 !== model('1, 64'd1, 1'b1, 1'b1, 3'd2, 1'b1)) begin
            n_fail++; $display("FAIL signed_both_ee1: got %h required %h", o1, model('1, 64'd1, 1'b1, 1'b1, 3'd2, 1'b1));
        end
    endtask

    task automatic test_early_exit();
        logic [15:0] o0, o1;
        do_txn(64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 3'd2, o0, o1);
        n_checks++;
        if (o1 !== {1'b1, 6'b001101, 1'b0, 8'd1}) begin
            n_fail++; $display("FAIL early_exit_msb_ee1: got %h required %h", o1, {1'b1, 6'b001101, 1'b0, 8'd1});
        end
        n_checks++;
        if (o0 !== {1'b1, 6'b001101, 1'b0, 8'd4}) begin
            n_fail++; $display("FAIL early_exit_msb_ee0: got %h required %h", o0, {1'b1, 6'b001101, 1'b0, 8'd4});
        end
        do_txn(64'h1234, 64'h1234, 1'b0, 1'b0, 3'd4, o0, o1);
        n_checks++;
        if (o1 !== {1'b1, 6'b010110, 1'b0, 8'd4}) begin
            n_fail++; $display("FAIL early_exit_equal_ee1: got %h required %h", o1, {1'b1, 6'b010110, 1'b0, 8'd4});
        end
    endtask

    task automatic test_illegal_op();
        logic [15:0] o0, o1;
        do_txn(64'd3, 64'd3, 1'b0, 1'b0, 3'd7, o0, o1);
        n_checks++;
        if (o0 !== {1'b0, 6'b010110, 1'b1, 8'd4}) begin
            n_fail++; $display("FAIL illegal_op: got %h required %h", o0, {1'b0, 6'b010110, 1'b1, 8'd4});
        end
        do_txn(64'd3, 64'd3, 1'b0, 1'b0, 3'd4, o0, o1);
        n_checks++;
        if (o0 !== {1'b1, 6'b010110, 1'b0, 8'd4}) begin
            n_fail++; $display("FAIL illegal_op_clear: got %h required %h", o0, {1'b1, 6'b010110, 1'b0, 8'd4});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  s0, s1, e0, e1;
        logic [15:0] m;
        logic [63:0] ta, tb;
        int n;
        ta = {$urandom, $urandom};
        tb = ta ^ (64'd1 << 40);
        n = 0;
        while (!(rdy0 && rdy1) && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        a = ta; b = tb; a_signed = 1'b1; b_signed = 1'b1; op = 3'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!(ov0 && ov1) && n < 20) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (!(ov0 && ov1)) begin n_fail++; $display("FAIL bp_valid_timeout: out_valid=%b/%b required 1/1", ov0, ov1); end
        s0 = {res0, vec0, err0};
        s1 = {res1, vec1, err1};
        m  = model(ta, tb, 1'b1, 1'b1, 3'd1, 1'b0);
        e0 = m[15:8];
        m  = model(ta, tb, 1'b1, 1'b1, 3'd1, 1'b1);
        e1 = m[15:8];
        n_checks++;
        if ({s0, s1} !== {e0, e1}) begin n_fail++; $display("FAIL bp_result: got %h required %h", {s0, s1}, {e0, e1}); end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'd4;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov0, rdy0, res0, vec0, err0, ov1, rdy1, res1, vec1, err1} !== {2'b10, s0, 2'b10, s1}) begin
                n_fail++;
                $display("FAIL bp_hold: got %h required %h",
                         {ov0, rdy0, res0, vec0, err0, ov1, rdy1, res1, vec1, err1}, {2'b10, s0, 2'b10, s1});
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({ov0, rdy0, ov1, rdy1} !== 4'b0101) begin
            n_fail++; $display("FAIL bp_release: got ov/rdy=%b required 0101", {ov0, rdy0, ov1, rdy1});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ov0, rdy0, ov1, rdy1} !== 4'b0101) begin
            n_fail++; $display("FAIL bp_pulse_ignored: got ov/rdy=%b required 0101", {ov0, rdy0, ov1, rdy1});
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] o0, o1, e0, e1;
        logic [63:0] ta;
        bit seen;
        ta = {$urandom, $urandom};
        out_ready = 1'b1;
        a = ta; b = ta ^ 64'd1; a_signed = 1'b0; b_signed = 1'b0; op = 3'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({ov0, vec0, ov1, vec1} !== 14'b0) begin
            n_fail++; $display("FAIL reset_mid_clear: got ov/vec=%b required 0", {ov0, vec0, ov1, vec1});
        end
        n_checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            n_fail++; $display("FAIL reset_mid_ready: got %b required 11", {rdy0, rdy1});
        end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ov0 || ov1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_valid: got out_valid seen=%b required 0", seen); end
        do_txn(ta, ta + 64'd9, 1'b0, 1'b0, 3'd1, o0, o1);
        e0 = model(ta, ta + 64'd9, 1'b0, 1'b0, 3'd1, 1'b0);
        e1 = model(ta, ta + 64'd9, 1'b0, 1'b0, 3'd1, 1'b1);
        n_checks++;
        if ({o0, o1} !== {e0, e1}) begin n_fail++; $display("FAIL reset_mid_next: got %h required %h", {o0, o1}, {e0, e1}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] o0, o1, e0, e1;
        logic [63:0] ta, tb;
        for (int k = 0; k < 3; k++) begin
            ta = {$urandom, $urandom};
            tb = ta - 64'(k);
            do_txn(ta, tb, 1'b0, 1'b0, 3'(k + 3), o0, o1);
            e0 = model(ta, tb, 1'b0, 1'b0, 3'(k + 3), 1'b0);
            e1 = model(ta, tb, 1'b0, 1'b0, 3'(k + 3), 1'b1);
            n_checks++;
            if ({o0, o1} !== {e0, e1}) begin n_fail++; $display("FAIL back_to_back: got %h required %h", {o0, o1}, {e0, e1}); end
            n_checks++;
            if ({rdy0, rdy1, ov0, ov1} !== 4'b1100) begin
                n_fail++; $display("FAIL back_to_back_idle: got rdy/ov=%b required 1100", {rdy0, rdy1, ov0, ov1});
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] o0, o1, e0, e1;
        logic [63:0] ta, tb;
        logic        tas, tbs;
        logic [2:0]  top;
        for (int k = 0; k < 60; k++) begin
            ta = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       tb = {$urandom, $urandom};
                1:       tb = ta;
                2:       tb = ta ^ (64'd1 << $urandom_range(0, 63));
                default: tb = {ta[63:32], 32'($urandom)};
            endcase
            tas = 1'($urandom);
            tbs = 1'($urandom);
            top = 3'($urandom_range(0, 7));
            do_txn(ta, tb, tas, tbs, top, o0, o1);
            e0 = model(ta, tb, tas, tbs, top, 1'b0);
            e1 = model(ta, tb, tas, tbs, top, 1'b1);
            n_checks++;
            if (o0 !== e0) begin n_fail++; $display("FAIL random_ee0 a=%h b=%h: got %h required %h", ta, tb, o0, e0); end
            n_checks++;
            if (o1 !== e1) begin n_fail++; $display("FAIL random_ee1 a=%h b=%h: got %h required %h", ta, tb, o1, e1); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_lt();
        test_signed_mix();
        test_early_exit();
        test_illegal_op();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
